// File: rtl/im_fetch_responder.sv
// Instruction-fetch responder: word-aligned fetch -> SRAM word index, WAIT wait states, one SRAM read, held response.
// Latency WAIT+2 edges past accept (bad address: RESP right after accept); response held until rsp_ready, flush wins.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef IM_BASE_ADDR
`define IM_BASE_ADDR 32'h0000_0000
`endif

module im_fetch_responder #(
    parameter int              AW         = `PC_WIDTH,
    parameter int              DEPTH_LOG2 = 10,
    parameter logic [AW-1:0]   BASE_ADDR  = `IM_BASE_ADDR,
    parameter int              WAIT       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AW-1:0]         req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic [AW-1:0]         rsp_addr,
    output logic                  mem_en,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_WSTATE, S_READ, S_FILL, S_RESP} state_e;

    localparam logic [AW-1:0] LIMIT   = AW'(4) << DEPTH_LOG2;
    localparam logic [2:0]    WAIT_M1 = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           data_q, data_d;
    logic                  err_q, err_d;
    logic [AW-1:0]         addr_q, addr_d;

    logic [AW-1:0]         offset;
    logic [DEPTH_LOG2-1:0] idx_w;
    logic                  bad_addr;
    logic                  accept;

    // Addresses below the base wrap to huge offsets, but are rejected explicitly as well.
    assign offset   = req_addr - BASE_ADDR;
    assign idx_w    = DEPTH_LOG2'(offset >> 2);
    assign bad_addr = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) || (offset >= LIMIT);

    assign req_ready = !flush && ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));
    assign accept    = req_valid && req_ready;

    assign rsp_valid = (state_q == S_RESP);
    assign mem_en    = (state_q == S_READ);
    assign mem_addr  = idx_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign rsp_addr  = addr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        err_d   = err_q;
        addr_d  = addr_q;

        case (state_q)
            S_WSTATE: begin
                if (cnt_q == 3'd0) state_d = S_READ;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_READ:   state_d = S_FILL;
            S_FILL: begin
                data_d  = mem_rdata;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP:   if (rsp_ready) state_d = S_IDLE;
            default:  ;
        endcase

        // An accept in RESP overrides the return to IDLE so back-to-back fetches lose no cycle.
        if (accept) begin
            addr_d = req_addr;
            idx_d  = idx_w;
            if (bad_addr) begin
                state_d = S_RESP;
                err_d   = 1'b1;
                data_d  = 32'd0;
            end else if (WAIT > 0) begin
                state_d = S_WSTATE;
                cnt_d   = WAIT_M1;
            end else begin
                state_d = S_READ;
            end
        end

        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= '0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_im_fetch_responder.sv
// Bench for im_fetch_responder: directed vector table, hand-written corner sequences, randomized traffic vs a transaction model.
module tb_im_fetch_responder;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic        req_ready, rsp_valid, rsp_err, mem_en;
    logic [31:0] rsp_data, rsp_addr;
    logic [31:0] mem_rdata = 32'd0;
    logic [3:0]  mem_addr;
    logic [3:0]  last_maddr = 4'd0;

    int checks = 0;
    int errors = 0;
    int men_cnt = 0;

    im_fetch_responder #(
        .AW(32), .DEPTH_LOG2(4), .BASE_ADDR(32'h0000_3000), .WAIT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_addr(rsp_addr),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: word i holds A000_0000 + i, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata  <= 32'hA000_0000 + 32'(mem_addr);
            last_maddr <= mem_addr;
            men_cnt    <= men_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [31:0] a, output logic err, output logic [31:0] d);
        logic [31:0] off;
        off = a - BASE;
        err = (a[1:0] != 2'b00) || (a < BASE) || (off >= 32'd64);
        d   = err ? 32'd0 : 32'hA000_0000 + (off >> 2);
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return BASE + 32'($urandom_range(0, 3));
            1:       return BASE - 32'(4 * $urandom_range(1, 4));
            2:       return BASE + 32'(4 * $urandom_range(16, 20));
            default: return BASE + 32'(4 * $urandom_range(0, 15));
        endcase
    endfunction

    // Issue one fetch with rsp_ready low; returns at the negedge where rsp_valid is seen (or timeout).
    task automatic fetch_one(input logic [31:0] a, output int lat, output int men);
        int m0;
        int b;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        m0 = men_cnt;
        b = 0;
        while (!req_ready && b < 20) begin
            @(negedge clk);
            b++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        men = men_cnt - m0;
    endtask

    task automatic release_rsp(input string nm);
        rsp_ready = 1'b1;
        #1;
        chk({nm, "_hs_req_ready"}, req_ready, 1);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, "_after_hs_valid"}, rsp_valid, 0);
    endtask

    task automatic quiet(input string nm, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk({nm, "_no_response"}, 32'(seen), 0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        err;
        logic [31:0] data;
        int          lat;
        int          men;
        logic [3:0]  idx;
    } vec_t;

    vec_t vt[6];

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, men, m0, nr, idx, nacc_hs, n, elat, ngood;
        int          rc[3];
        logic        pend, outst, eerr, exp_v, exp_r;
        logic [31:0] edat, eaddr, first_data;

        vt[0] = '{32'h0000_3008, 1'b0, 32'hA000_0002, 5, 1, 4'd2};
        vt[1] = '{32'h0000_3002, 1'b1, 32'h0000_0000, 1, 0, 4'd0};
        vt[2] = '{32'h0000_2FFC, 1'b1, 32'h0000_0000, 1, 0, 4'd0};
        vt[3] = '{32'h0000_3040, 1'b1, 32'h0000_0000, 1, 0, 4'd0};
        vt[4] = '{32'h0000_3000, 1'b0, 32'hA000_0000, 5, 1, 4'd0};
        vt[5] = '{32'h0000_303C, 1'b0, 32'hA000_000F, 5, 1, 4'd15};

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_req_ready", req_ready, 1);
        #10 rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            fetch_one(vt[i].addr, lat, men);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d_err", i), rsp_err, vt[i].err);
            chk($sformatf("v%0d_data", i), rsp_data, vt[i].data);
            chk($sformatf("v%0d_addr", i), rsp_addr, vt[i].addr);
            chk($sformatf("v%0d_mem_en_count", i), 32'(men), 32'(vt[i].men));
            if (!vt[i].err) chk($sformatf("v%0d_mem_addr", i), 32'(last_maddr), 32'(vt[i].idx));
            if (i == 5) begin
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    chk($sformatf("hold%0d_valid", k), rsp_valid, 1);
                    chk($sformatf("hold%0d_data", k), rsp_data, 32'hA000_000F);
                    chk($sformatf("hold%0d_req_ready", k), req_ready, 0);
                end
            end
            release_rsp($sformatf("v%0d", i));
        end

        // Back-to-back fetches with accept on the response handshake edge
        nr = 0; idx = 0; nacc_hs = 0; pend = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_3000; rsp_ready = 1'b1;
        for (int c = 0; c < 40 && nr < 3; c++) begin
            #1;
            pend = req_valid && req_ready;
            if (pend && rsp_valid) nacc_hs++;
            @(negedge clk);
            if (rsp_valid) begin
                chk($sformatf("b2b%0d_data", nr), rsp_data, 32'hA000_0000 + 32'(nr));
                rc[nr] = c;
                nr++;
            end
            if (pend) begin
                idx++;
                if (idx < 3) req_addr = 32'h0000_3000 + 32'(4 * idx);
                else         req_valid = 1'b0;
            end
        end
        chk("b2b_responses", 32'(nr), 3);
        chk("b2b_accept_on_hs", 32'(nacc_hs), 2);
        if (nr == 3) begin
            chk("b2b_spacing01", 32'(rc[1] - rc[0]), 5);
            chk("b2b_spacing12", 32'(rc[2] - rc[1]), 5);
        end
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b0;
        chk("b2b_drained", rsp_valid, 0);

        // Flush during WSTATE
        m0 = men_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_3010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b1;
        #1 chk("flush_blocks_ready", req_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush1_idle_ready", req_ready, 1);
        chk("flush1_valid", rsp_valid, 0);
        quiet("flush1", 8);
        chk("flush1_no_mem_en", 32'(men_cnt - m0), 0);

        // Flush during READ
        m0 = men_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_3020;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("flush2_in_read", mem_en, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush2_idle_ready", req_ready, 1);
        chk("flush2_valid", rsp_valid, 0);
        quiet("flush2", 8);
        chk("flush2_mem_en_once", 32'(men_cnt - m0), 1);

        fetch_one(32'h0000_3014, lat, men);
        chk("post_flush_latency", 32'(lat), 5);
        chk("post_flush_data", rsp_data, 32'hA000_0005);
        chk("post_flush_err", rsp_err, 0);
        release_rsp("post_flush");

        // Reset during FILL
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_3018;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_fill_state", mem_en, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", rsp_valid, 0);
        chk("rst_mid_data", rsp_data, 0);
        chk("rst_mid_err", rsp_err, 0);
        chk("rst_mid_addr", rsp_addr, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        #1 rst_n = 1'b1;
        quiet("rst_mid", 10);

        // Randomized traffic against the transaction model
        outst = 1'b0; n = 0; elat = 0; eerr = 1'b0; edat = 32'd0; eaddr = 32'd0; ngood = 0;
        m0 = men_cnt;
        first_data = 32'd0;
        @(negedge clk);
        for (int c = 0; c < 800; c++) begin
            if (outst) n++;
            exp_v = outst && (n >= elat);
            chk("rnd_valid", rsp_valid, exp_v);
            if (exp_v) begin
                chk("rnd_data", rsp_data, edat);
                chk("rnd_err", rsp_err, eerr);
                chk("rnd_addr", rsp_addr, eaddr);
            end
            chk("rnd_mem_en", mem_en, outst && !eerr && (n == 3));
            if (outst && !eerr && n == 3) chk("rnd_mem_addr", 32'(mem_addr), 32'(4'((eaddr - BASE) >> 2)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_valid = $urandom_range(0, 1) == 1;
            req_addr  = rand_addr();
            #1;
            exp_r = !outst || (exp_v && rsp_ready);
            chk("rnd_req_ready", req_ready, exp_r);
            if (exp_v && rsp_ready) outst = 1'b0;
            if (req_valid && req_ready) begin
                outst = 1'b1;
                n     = 0;
                eaddr = req_addr;
                model(req_addr, eerr, edat);
                elat  = eerr ? 1 : 5;
                if (!eerr) ngood++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("rnd_mem_en_total", 32'(men_cnt - m0), 32'(ngood));
        chk("rnd_drained", rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
